// File: rtl/register_dump_tx_pkg.sv
// Shared constants for the register dump streamer: FSM encodings, byte geometry
// helpers and the checksum seed/step used when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_pkg;

  localparam int DEF_SIZE          = 32;
  localparam int DEF_NUM_REGISTERS = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_CSUM = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [7:0] CSUM_INIT = 8'h00;

  function automatic int bytes_per_reg(input int size);
    return size / 8;
  endfunction

  // A single-byte register still needs a 1-bit index to keep the ports legal.
  function automatic int byte_idx_w(input int size);
    return (size / 8 > 1) ? $clog2(size / 8) : 1;
  endfunction

  localparam int BYTES_PER_REG = bytes_per_reg(DEF_SIZE);
  localparam int BYTE_IDX_W    = byte_idx_w(DEF_SIZE);

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/register_dump_tx_if.sv
// Byte stream handshake from the register dump engine to the debug UART TX.
interface register_dump_tx_if;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;

  modport master (output o_tx_data, output o_tx_valid, input i_tx_ready);
  modport slave  (input o_tx_data, input o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/register_dump_tx.sv
// Snapshots the flattened register-bank debug vector on i_start and streams it
// MSB byte first over a valid/ready link; REG_DUMP_CHECKSUM_EN appends an XOR byte.
module register_dump_tx
  import reg_dump_pkg::*;
#(
  parameter int SIZE          = DEF_SIZE,
  parameter int NUM_REGISTERS = DEF_NUM_REGISTERS,
  parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [SIZE*NUM_REGISTERS-1:0] i_registers_debug,
  register_dump_tx_if.master            tx,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int BPR   = bytes_per_reg(SIZE);
  localparam int BW    = byte_idx_w(SIZE);
  localparam int VEC_W = SIZE * NUM_REGISTERS;
  localparam int OFF_W = $clog2(VEC_W);

  localparam logic [SIZE_REG_DIR-1:0] LAST_REG  = SIZE_REG_DIR'(NUM_REGISTERS - 1);
  localparam logic [BW-1:0]           LAST_BYTE = BW'(BPR - 1);

  state_t                  state_q, state_d;
  logic [VEC_W-1:0]        snap_q, snap_d;
  logic [SIZE_REG_DIR-1:0] reg_idx_q, reg_idx_d;
  logic [BW-1:0]           byte_idx_q, byte_idx_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  logic                    xfer_s;
  logic                    last_s;
  logic [SIZE_REG_DIR-1:0] reg_nxt_s;
  logic [BW-1:0]           byte_nxt_s;
  logic [OFF_W-1:0]        off_nxt_s;
  logic [7:0]              nxt_byte_s;

  // Handshake decode and lookahead of the byte that follows the current one.
  always_comb begin
    xfer_s = tx_valid_q & tx.i_tx_ready;
    last_s = (reg_idx_q == LAST_REG) && (byte_idx_q == LAST_BYTE);
    if (byte_idx_q == LAST_BYTE) begin
      byte_nxt_s = '0;
      reg_nxt_s  = reg_idx_q + SIZE_REG_DIR'(1);
    end else begin
      byte_nxt_s = byte_idx_q + BW'(1);
      reg_nxt_s  = reg_idx_q;
    end
    off_nxt_s  = OFF_W'(reg_nxt_s) * OFF_W'(SIZE) + OFF_W'(SIZE - 8)
               - (OFF_W'(byte_nxt_s) << 3);
    nxt_byte_s = snap_q[off_nxt_s +: 8];
  end

  // Dump sequencer: outputs are computed one cycle ahead so every port is a flop.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          // First byte comes straight from the live vector; the snapshot lands this edge.
          state_d    = ST_SEND;
          snap_d     = i_registers_debug;
          reg_idx_d  = '0;
          byte_idx_d = '0;
          tx_data_d  = i_registers_debug[SIZE-1 -: 8];
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d     = CSUM_INIT;
`endif
        end else begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      end

      ST_SEND: begin
        if (xfer_s && last_s) begin
`ifdef REG_DUMP_CHECKSUM_EN
          state_d    = ST_CSUM;
          csum_d     = csum_step(csum_q, tx_data_q);
          tx_data_d  = csum_step(csum_q, tx_data_q);
`else
          state_d    = ST_DONE;
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
`endif
        end else if (xfer_s) begin
          reg_idx_d  = reg_nxt_s;
          byte_idx_d = byte_nxt_s;
          tx_data_d  = nxt_byte_s;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d     = csum_step(csum_q, tx_data_q);
`endif
        end else begin
          tx_data_d  = tx_data_q;
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer_s) begin
          state_d    = ST_DONE;
          tx_data_d  = 8'h00;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          tx_data_d  = tx_data_q;
        end
      end
`endif

      ST_DONE: begin
        state_d    = ST_IDLE;
        reg_idx_d  = '0;
        byte_idx_d = '0;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end

      default: begin
        state_d    = ST_IDLE;
        reg_idx_d  = '0;
        byte_idx_d = '0;
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q     <= CSUM_INIT;
`endif
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx.o_tx_data  = tx_data_q;
  assign tx.o_tx_valid = tx_valid_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_register_dump_tx.sv
// Directed scoreboard bench for register_dump_tx; honours REG_DUMP_CHECKSUM_EN.
module tb_register_dump_tx;

  localparam int SIZE = 32;
  localparam int NREG = 32;
  localparam int BPR  = SIZE / 8;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int NBYTES = NREG * BPR + 1;
`else
  localparam int NBYTES = NREG * BPR;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_start;
  logic [SIZE*NREG-1:0] regs;
  logic                 o_busy;
  logic                 o_done;

  register_dump_tx_if tx_if ();

  register_dump_tx #(.SIZE(SIZE), .NUM_REGISTERS(NREG)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_registers_debug (regs),
    .tx                (tx_if),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_bytes [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_dump(input logic [SIZE*NREG-1:0] v);
    logic [7:0] x;
    logic [7:0] bt;
    x = 8'h00;
    for (int r = 0; r < NREG; r++) begin
      for (int b = 0; b < BPR; b++) begin
        bt = v[r*SIZE + SIZE - 1 - 8*b -: 8];
        x  = x ^ bt;
        exp_q.push_back(bt);
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic set_pattern();
    for (int k = 0; k < NREG; k++) regs[k*SIZE +: SIZE] = 32'(k) * 32'h100 + 32'(k);
  endtask

  // Drives one start and monitors the stream on negedges until done+1 or abort.
  task automatic run_dump(input bit rand_ready, input int pulse_at, input int abort_at,
                          input bit clobber, output int nbytes, output int busy_cyc,
                          output int done_cnt);
    int         cyc;
    int         last_xfer;
    bit         stalled;
    bit         fin;
    bit         ready_v;
    logic [7:0] stall_data;
    logic [7:0] exp_b;
    nbytes = 0; busy_cyc = 0; done_cnt = 0; last_xfer = -10;
    stalled = 1'b0; fin = 1'b0; cyc = 0; stall_data = 8'h00;
    @(negedge clk);
    i_start = 1'b1;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      i_start = (pulse_at >= 0 && nbytes == pulse_at) ? 1'b1 : 1'b0;
      if (clobber && cyc == 1) regs = '1;
      if (stalled) check("stall_hold", 32'(tx_if.o_tx_data), 32'(stall_data));
      if (abort_at >= 0 && nbytes == abort_at && tx_if.o_tx_valid) begin
        rst = 1'b0;
        tx_if.i_tx_ready = 1'b0;
        fin = 1'b1;
      end else begin
        ready_v = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        tx_if.i_tx_ready = ready_v;
        if (o_busy) busy_cyc++;
        if (o_done) begin
          done_cnt++;
          check("done_after_last", 32'(cyc - last_xfer), 32'd1);
        end
        if (tx_if.o_tx_valid && ready_v) begin
          exp_b = 8'hxx;
          if (exp_q.size() > 0) exp_b = exp_q.pop_front();
          check("byte", 32'(tx_if.o_tx_data), 32'(exp_b));
          if (nbytes < 256) obs_bytes[nbytes] = tx_if.o_tx_data;
          nbytes++;
          last_xfer = cyc;
          stalled = 1'b0;
        end else if (tx_if.o_tx_valid) begin
          stalled = 1'b1;
          stall_data = tx_if.o_tx_data;
        end else begin
          stalled = 1'b0;
        end
        if (done_cnt > 0 && !o_done) begin
          check("idle_valid", 32'(tx_if.o_tx_valid), 32'd0);
          check("idle_busy", 32'(o_busy), 32'd0);
          fin = 1'b1;
        end
      end
    end
    check("dump_terminated", 32'(fin), 32'd1);
    i_start = 1'b0;
  endtask

  int nb, bc, dc;

  initial begin
    rst = 1'b0;
    i_start = 1'b1;
    tx_if.i_tx_ready = 1'b1;
    set_pattern();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(tx_if.o_tx_valid), 32'd0);
    check("rst_data", 32'(tx_if.o_tx_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    rst = 1'b1;
    i_start = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(tx_if.o_tx_valid), 32'd0);

    // Full dump, ready tied high.
    push_dump(regs);
    run_dump(1'b0, -1, -1, 1'b0, nb, bc, dc);
    check("full_bytes", 32'(nb), 32'(NBYTES));
    check("full_busy", 32'(bc), 32'(NBYTES));
    check("full_done_cnt", 32'(dc), 32'd1);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);
    check("reg1_b0", 32'(obs_bytes[4]), 32'h00);
    check("reg1_b1", 32'(obs_bytes[5]), 32'h00);
    check("reg1_b2", 32'(obs_bytes[6]), 32'h01);
    check("reg1_b3", 32'(obs_bytes[7]), 32'h01);
    check("reg31_b3", 32'(obs_bytes[127]), 32'h1f);

    // Random back-pressure with random contents.
    for (int k = 0; k < NREG; k++) regs[k*SIZE +: SIZE] = $urandom();
    push_dump(regs);
    run_dump(1'b1, -1, -1, 1'b0, nb, bc, dc);
    check("rand_bytes", 32'(nb), 32'(NBYTES));
    check("rand_done_cnt", 32'(dc), 32'd1);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Snapshot isolation: vector goes all ones one cycle after start.
    set_pattern();
    push_dump(regs);
    run_dump(1'b0, -1, -1, 1'b1, nb, bc, dc);
    check("snap_bytes", 32'(nb), 32'(NBYTES));
    check("snap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Mid-dump start pulse ignored, then reset at byte 40 aborts.
    set_pattern();
    push_dump(regs);
    run_dump(1'b0, 10, 40, 1'b0, nb, bc, dc);
    check("abort_bytes", 32'(nb), 32'd40);
    @(negedge clk);
    check("abort_valid", 32'(tx_if.o_tx_valid), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    rst = 1'b1;
    tx_if.i_tx_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(o_done), 32'd0);
      check("abort_no_valid", 32'(tx_if.o_tx_valid), 32'd0);
    end
    push_dump(regs);
    run_dump(1'b0, -1, -1, 1'b0, nb, bc, dc);
    check("restart_bytes", 32'(nb), 32'(NBYTES));
    check("restart_first", 32'(obs_bytes[0]), 32'h00);
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef REG_DUMP_CHECKSUM_EN
    regs = '0;
    regs[1*SIZE +: SIZE] = 32'hFF00_FF00;
    push_dump(regs);
    run_dump(1'b0, -1, -1, 1'b0, nb, bc, dc);
    check("csum0_bytes", 32'(nb), 32'd129);
    check("csum0_last", 32'(obs_bytes[128]), 32'h00);
    regs[1*SIZE +: SIZE] = 32'h0000_00A5;
    push_dump(regs);
    run_dump(1'b1, -1, -1, 1'b0, nb, bc, dc);
    check("csumA5_bytes", 32'(nb), 32'd129);
    check("csumA5_last", 32'(obs_bytes[128]), 32'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
